// File: rtl/mouse_paint_pkg.sv
// Shared state encoding, palette and packet layout for the mouse paint engine.
// Pure declarations: no latency or backpressure of its own.
package mouse_paint_pkg;

    localparam int RGB_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        PAINT = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // Ascending range so PALETTE[0] is the first (reset) colour.
    localparam logic [0:7][RGB_W-1:0] PALETTE = {
        12'hFFF, 12'hF00, 12'h0F0, 12'h00F,
        12'hFF0, 12'h0FF, 12'hF0F, 12'h000
    };

    typedef struct packed {
        logic [8:0] dx;
        logic [8:0] dy;
        logic       xovf;
        logic       yovf;
        logic [2:0] btn;
    } pkt_t;

    function automatic logic signed [10:0] sext_delta(input logic [8:0] d, input logic ovf);
        return ovf ? 11'sd0 : $signed({{2{d[8]}}, d});
    endfunction

endpackage

// File: rtl/coord_clamp.sv
// Clamps a signed 11-bit coordinate into [0, N-1]; combinational.
// No latency, no flow control.
module coord_clamp #(
    parameter  int N = 64,
    localparam int W = $clog2(N)
) (
    input  logic signed [10:0] sum,
    output logic [W-1:0]       idx
);

    localparam logic signed [10:0] MAXV = 11'(N - 1);

    always_comb begin
        if (sum < 0)
            idx = '0;
        else if (sum > MAXV)
            idx = W'(N - 1);
        else
            idx = sum[W-1:0];
    end

endmodule

// File: rtl/mouse_paint_writer.sv
// Mouse paint engine: clamped cursor update, 2x2 brush while left held, full clear on right.
// Cursor valid 2 cycles after accept; pkt_ready low in MOVE/PAINT/CLEAR (upstream holds the packet).
module mouse_paint_writer
    import mouse_paint_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    input  logic [8:0]       pkt_dx,
    input  logic [8:0]       pkt_dy,
    input  logic             pkt_xovf,
    input  logic             pkt_yovf,
    input  logic [2:0]       pkt_btn,
    output logic             wr_en,
    output logic [YW+XW-1:0] wr_addr,
    output logic [RGB_W-1:0] wr_data,
    output logic [XW-1:0]    cur_x,
    output logic [YW-1:0]    cur_y,
    output logic [RGB_W-1:0] color,
    output logic             busy
);

    localparam int             AW    = XW + YW;
    localparam logic [AW:0]    NPIX  = (AW+1)'(WIDTH * HEIGHT);
    localparam logic [AW:0]    NBRSH = (AW+1)'(4);

    state_t            state, state_nx;
    pkt_t              pkt_q;
    logic [2:0]        pal_idx, pal_nx;
    logic              mid_prev;
    logic [AW:0]       cnt;

    logic signed [10:0] sum_x, sum_y;
    logic [XW-1:0]      nx;
    logic [YW-1:0]      ny;

    logic [1:0]         bsel;
    logic [XW:0]        tx;
    logic [YW:0]        ty;
    logic               brush_ok;
    logic [RGB_W-1:0]   brush_col;

    assign pkt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Screen row 0 is at the top, so positive dy moves the cursor up (row decreases).
    assign sum_x  = $signed({{(11-XW){1'b0}}, cur_x}) + sext_delta(pkt_q.dx, pkt_q.xovf);
    assign sum_y  = $signed({{(11-YW){1'b0}}, cur_y}) - sext_delta(pkt_q.dy, pkt_q.yovf);
    assign pal_nx = pal_idx + 3'(pkt_q.btn[2] && !mid_prev);

    coord_clamp #(.N(WIDTH))  u_clamp_x (.sum(sum_x), .idx(nx));
    coord_clamp #(.N(HEIGHT)) u_clamp_y (.sum(sum_y), .idx(ny));

    // Brush pixel 0 is issued from MOVE using the freshly computed cursor and colour.
    always_comb begin
        bsel      = 2'd0;
        tx        = {1'b0, nx};
        ty        = {1'b0, ny};
        brush_col = PALETTE[pal_nx];
        if (state != MOVE) begin
            bsel      = cnt[1:0];
            tx        = {1'b0, cur_x} + (XW+1)'(bsel[0]);
            ty        = {1'b0, cur_y} + (YW+1)'(bsel[1]);
            brush_col = color;
        end
        brush_ok = !tx[XW] && !ty[YW];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (pkt_valid) state_nx = MOVE;
            MOVE: begin
                if (pkt_q.btn[1])      state_nx = CLEAR;
                else if (pkt_q.btn[0]) state_nx = PAINT;
                else                   state_nx = IDLE;
            end
            PAINT: if (cnt == NBRSH) state_nx = IDLE;
            CLEAR: if (cnt == NPIX)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q    <= '0;
            cur_x    <= XW'(WIDTH / 2);
            cur_y    <= YW'(HEIGHT / 2);
            pal_idx  <= 3'd0;
            color    <= PALETTE[0];
            mid_prev <= 1'b0;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_valid)
                        pkt_q <= '{dx: pkt_dx, dy: pkt_dy, xovf: pkt_xovf,
                                   yovf: pkt_yovf, btn: pkt_btn};
                end
                MOVE: begin
                    cur_x    <= nx;
                    cur_y    <= ny;
                    pal_idx  <= pal_nx;
                    color    <= PALETTE[pal_nx];
                    mid_prev <= pkt_q.btn[2];
                    cnt      <= (AW+1)'(1);
                    if (pkt_q.btn[1]) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= '0;
                    end else if (pkt_q.btn[0]) begin
                        wr_en   <= brush_ok;
                        wr_addr <= {ty[YW-1:0], tx[XW-1:0]};
                        wr_data <= brush_col;
                    end
                end
                PAINT: begin
                    if (cnt != NBRSH) begin
                        wr_en   <= brush_ok;
                        wr_addr <= {ty[YW-1:0], tx[XW-1:0]};
                        wr_data <= brush_col;
                        cnt     <= cnt + (AW+1)'(1);
                    end
                end
                CLEAR: begin
                    if (cnt != NPIX) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[AW-1:0];
                        wr_data <= '0;
                        cnt     <= cnt + (AW+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_paint_writer.sv
// Random and directed packets against a cursor/palette/write-list model of the paint engine.
module tb_mouse_paint_writer;

    localparam int W = 64, H = 64, XW = 6, YW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [8:0]       pkt_dx, pkt_dy;
    logic             pkt_xovf, pkt_yovf;
    logic [2:0]       pkt_btn;
    logic             wr_en;
    logic [YW+XW-1:0] wr_addr;
    logic [11:0]      wr_data;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic [11:0]      color;
    logic             busy;

    mouse_paint_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_dx(pkt_dx), .pkt_dy(pkt_dy),
        .pkt_xovf(pkt_xovf), .pkt_yovf(pkt_yovf), .pkt_btn(pkt_btn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_x(cur_x), .cur_y(cur_y), .color(color), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    int mx, my, mpi;
    bit mmid;
    int pal[8] = '{'hFFF, 'hF00, 'h0F0, 'h00F, 'hFF0, 'h0FF, 'hF0F, 'h000};
    int nclr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int clampi(input int v, input int n);
        return (v < 0) ? 0 : ((v > n - 1) ? n - 1 : v);
    endfunction

    task automatic model_reset();
        mx = W / 2; my = H / 2; mpi = 0; mmid = 1'b0;
    endtask

    // Sends one packet, then follows it cycle by cycle until pkt_ready returns.
    // abort_at >= 0 asserts rst when that clear address is seen on the write port.
    task automatic send(input logic [8:0] dx, input logic [8:0] dy, input logic xo,
                        input logic yo, input logic [2:0] btn, input int abort_at);
        logic [63:0] expw[$];
        logic [63:0] obs;
        int lat, k, nw, busy_err, sdx, sdy, x, y;

        sdx = xo ? 0 : int'($signed(dx));
        sdy = yo ? 0 : int'($signed(dy));
        mx = clampi(mx + sdx, W);
        my = clampi(my - sdy, H);
        if (btn[2] && !mmid) mpi = (mpi + 1) % 8;
        mmid = btn[2];
        if (btn[1]) begin
            lat = 2 + W * H;
            for (int a = 0; a < W * H; a++)
                expw.push_back({16'(a + 2), 16'(a), 12'h000});
        end else if (btn[0]) begin
            lat = 6;
            for (int b = 0; b < 4; b++) begin
                x = mx + (b & 1);
                y = my + (b >> 1);
                if (x < W && y < H)
                    expw.push_back({16'(b + 2), 16'(y * W + x), 12'(pal[mpi])});
            end
        end else begin
            lat = 2;
        end

        k = 0;
        while (!pkt_ready && k < 6000) begin @(negedge clk); k++; end
        chk("ready_before_send", pkt_ready, 1'b1);

        pkt_dx = dx; pkt_dy = dy; pkt_xovf = xo; pkt_yovf = yo; pkt_btn = btn;
        pkt_valid = 1'b1;
        @(posedge clk);
        #1 pkt_valid = 1'b0;

        k = 0; nw = 0; busy_err = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy !== !pkt_ready) busy_err++;
            if (k == 2) begin
                chk("cur_x", cur_x, mx);
                chk("cur_y", cur_y, my);
                chk("color", color, pal[mpi]);
            end
            if (wr_en) begin
                obs = {16'(k), 16'(wr_addr), 12'(wr_data)};
                if (nw < expw.size()) begin
                    if (!btn[1] || obs !== expw[nw]) chk("write{cyc,addr,data}", obs, expw[nw]);
                end else begin
                    chk("unexpected_write{cyc,addr,data}", obs, 64'd0);
                end
                nw++;
                if (abort_at >= 0 && int'(wr_addr) == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("abort_wr_en", wr_en, 1'b0);
                    chk("abort_cur_x", cur_x, W / 2);
                    chk("abort_cur_y", cur_y, H / 2);
                    chk("abort_color", color, 12'hFFF);
                    chk("abort_busy", busy, 1'b0);
                    @(negedge clk);
                    rst = 1'b0;
                    model_reset();
                    @(negedge clk);
                    chk("ready_after_abort", pkt_ready, 1'b1);
                    chk("wr_en_after_abort", wr_en, 1'b0);
                    return;
                end
            end
        end while (!pkt_ready && k < 6000);

        chk("ready_latency", k, lat);
        chk("write_count", nw, expw.size());
        chk("busy_vs_ready", busy_err, 0);
    endtask

    initial begin
        int d;
        logic [2:0] b;
        rst = 1'b1; pkt_valid = 1'b0;
        pkt_dx = '0; pkt_dy = '0; pkt_xovf = 1'b0; pkt_yovf = 1'b0; pkt_btn = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cur_x", cur_x, 32);
        chk("rst_cur_y", cur_y, 32);
        chk("rst_color", color, 12'hFFF);
        chk("rst_ready", pkt_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        send(9'd5, 9'd3, 0, 0, 3'b000, -1);                  // -> (37,29)
        send(9'd25, 9'd19, 0, 0, 3'b000, -1);                // -> (62,10)
        send(9'd100, 9'd0, 0, 0, 3'b000, -1);                // clamp right -> 63
        send(9'h19C, 9'd100, 0, 0, 3'b000, -1);              // -100,+100 -> (0,0)
        send(9'h1FF, 9'd1, 0, 0, 3'b000, -1);                // stays (0,0)
        send(9'd5, 9'd0, 1, 0, 3'b000, -1);                  // xovf ignores dx
        send(9'd100, 9'h19C, 0, 0, 3'b001, -1);              // to (63,63), paint one pixel
        send(9'h1F0, 9'd10, 0, 0, 3'b001, -1);               // interior brush, 4 writes
        send(9'd0, 9'd0, 0, 0, 3'b100, -1);                  // FFF -> F00
        send(9'd0, 9'd0, 0, 0, 3'b100, -1);
        send(9'd0, 9'd0, 0, 0, 3'b100, -1);
        send(9'd0, 9'd0, 0, 0, 3'b000, -1);
        send(9'd0, 9'd0, 0, 0, 3'b100, -1);                  // -> 0F0
        send(9'd3, 9'd3, 0, 0, 3'b011, -1);                  // clear only
        send(9'd7, 9'd2, 0, 0, 3'b010, 20);                  // reset mid-clear

        for (int i = 0; i < 60; i++) begin
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) - 256
                                             : int'($urandom_range(0, 40)) - 20;
            pkt_dy = '0;
            b = 3'($urandom_range(0, 7));
            if (b[1] && (nclr >= 2 || $urandom_range(0, 5) != 0)) b[1] = 1'b0;
            if (b[1]) nclr++;
            send(9'(d), 9'(int'($urandom_range(0, 40)) - 20),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), b, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
